// File: rtl/fa_serial_sched.sv
// Shares one external single-bit full adder between two requesters, computing
// WIDTH-bit sums LSB first with round-robin arbitration and one operation in flight.
module fa_serial_sched #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       r_state;
   logic             r_last_grant;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum_sh;
   logic             r_carry;
   logic             r_id;
   logic [CW-1:0]    r_cnt;

   logic             w_idle;
   logic             w_run;
   logic             w_done;
   logic             w_grant1;
   logic             w_accept;
   logic [WIDTH-1:0] w_sum_next;

   always_comb begin
      w_idle   = (r_state == ST_IDLE);
      w_run    = (r_state == ST_RUN);
      w_done   = (r_state == ST_DONE);
      // On a tie, requester 1 wins only if requester 0 was served last.
      w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
      w_accept = w_idle & (req0_valid | req1_valid);
   end

   always_comb begin
      w_sum_next            = r_sum_sh >> 1;
      w_sum_next[WIDTH-1]   = fa_sum;
   end

   always_comb begin
      req0_ready = ~rst & w_idle & req0_valid & ~w_grant1;
      req1_ready = ~rst & w_idle & w_grant1;
      fa_a       = w_run & r_a_sh[0];
      fa_b       = w_run & r_b_sh[0];
      fa_cin     = w_run & r_carry;
      rsp_valid  = w_done;
      rsp_id     = w_done & r_id;
      rsp_sum    = w_done ? r_sum_sh : '0;
      rsp_cout   = w_done & r_carry;
      busy       = w_run | w_done;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_a_sh       <= '0;
         r_b_sh       <= '0;
         r_sum_sh     <= '0;
         r_carry      <= 1'b0;
         r_id         <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a_sh  <= w_grant1 ? req1_a : req0_a;
                  r_b_sh  <= w_grant1 ? req1_b : req0_b;
                  r_carry <= w_grant1 ? req1_cin : req0_cin;
                  r_id    <= w_grant1;
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_sum_sh <= w_sum_next;
               r_carry  <= fa_cout;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  r_last_grant <= r_id;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fa_serial_sched.sv
// Bench for fa_serial_sched: WIDTH=8 instance driven by directed and random operations
// against an arithmetic model, plus a WIDTH=1 instance swept over the full-adder table.
module tb_fa_serial_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         n_checks = 0;
   int         n_fail = 0;
   logic       tb_last = 1'b1;

   logic       req0_valid = 0, req1_valid = 0, req0_cin = 0, req1_cin = 0;
   logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic       req0_ready, req1_ready;
   logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
   logic       rsp_valid, rsp_id, rsp_cout, busy;
   logic       rsp_ready = 0;
   logic [7:0] rsp_sum;

   logic       w1_req0_valid = 0, w1_req0_cin = 0, w1_rsp_ready = 0;
   logic [0:0] w1_req0_a = 0, w1_req0_b = 0, w1_req1_a = 0, w1_req1_b = 0;
   logic       w1_req1_valid = 0, w1_req1_cin = 0;
   logic       w1_req0_ready, w1_req1_ready;
   logic       w1_fa_a, w1_fa_b, w1_fa_cin, w1_fa_sum, w1_fa_cout;
   logic       w1_rsp_valid, w1_rsp_id, w1_rsp_cout, w1_busy;
   logic [0:0] w1_rsp_sum;

   always #5 clk = ~clk;

   assign fa_sum     = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout    = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
   assign w1_fa_sum  = w1_fa_a ^ w1_fa_b ^ w1_fa_cin;
   assign w1_fa_cout = (w1_fa_a & w1_fa_b) | (w1_fa_a & w1_fa_cin) | (w1_fa_b & w1_fa_cin);

   fa_serial_sched #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_cin(req1_cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .busy(busy)
   );

   fa_serial_sched #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(w1_req0_valid), .req0_ready(w1_req0_ready), .req0_a(w1_req0_a),
      .req0_b(w1_req0_b), .req0_cin(w1_req0_cin),
      .req1_valid(w1_req1_valid), .req1_ready(w1_req1_ready), .req1_a(w1_req1_a),
      .req1_b(w1_req1_b), .req1_cin(w1_req1_cin),
      .fa_a(w1_fa_a), .fa_b(w1_fa_b), .fa_cin(w1_fa_cin), .fa_sum(w1_fa_sum),
      .fa_cout(w1_fa_cout),
      .rsp_valid(w1_rsp_valid), .rsp_ready(w1_rsp_ready), .rsp_id(w1_rsp_id),
      .rsp_sum(w1_rsp_sum), .rsp_cout(w1_rsp_cout), .busy(w1_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, fa_a, fa_b, fa_cin,
                  busy, rsp_sum}, 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_all_zero("reset_outputs");
      @(negedge clk);
      rst = 1'b0;
      tb_last = 1'b1;
   endtask

   // One full operation: called at a negedge in IDLE with request inputs already set.
   task automatic serve(input int bp, input bit rr_early, input bit drop);
      logic       win;
      logic [7:0] a, b, m;
      logic       ci;
      logic [8:0] full;
      logic [8:0] part;
      #1;
      win  = (req0_valid && req1_valid) ? ~tb_last : req1_valid;
      a    = win ? req1_a : req0_a;
      b    = win ? req1_b : req0_b;
      ci   = win ? req1_cin : req0_cin;
      full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      check("grant_ready", {req0_ready, req1_ready}, {~win, win});
      check("idle_busy", busy, 1'b0);
      @(negedge clk);
      if (win) begin
         req1_a = 8'($urandom); req1_b = 8'($urandom);
         if (drop) req1_valid = 1'b0;
      end else begin
         req0_a = 8'($urandom); req0_b = 8'($urandom);
         if (drop) req0_valid = 1'b0;
      end
      rsp_ready = rr_early;
      for (int i = 0; i < 8; i++) begin
         m    = 8'((9'd1 << i) - 9'd1);
         part = ({1'b0, a & m} + {1'b0, b & m} + {8'd0, ci}) >> i;
         check("run_fa_a", fa_a, a[i]);
         check("run_fa_b", fa_b, b[i]);
         check("run_fa_cin", fa_cin, part[0]);
         check("run_ready", {req0_ready, req1_ready, rsp_valid, busy}, 4'b0001);
         @(negedge clk);
      end
      for (int i = 0; i <= (rr_early ? 0 : bp); i++) begin
         check("done_valid", {rsp_valid, busy, req0_ready, req1_ready}, 4'b1100);
         check("done_sum", rsp_sum, full[7:0]);
         check("done_cout", rsp_cout, full[8]);
         check("done_id", rsp_id, win);
         check("done_fa", {fa_a, fa_b, fa_cin}, 3'b000);
         if (i == (rr_early ? 0 : bp)) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      check("after_handshake", {rsp_valid, busy}, 2'b00);
      tb_last = win;
   endtask

   initial begin
      logic [1:0] tbl [8];
      int         v;
      tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      do_reset();

      // single add from requester 0
      req0_a = 8'hA5; req0_b = 8'h3C; req0_cin = 1'b0; req0_valid = 1'b1;
      serve(0, 1'b0, 1'b1);

      // overflow on requester 1
      req1_a = 8'hFF; req1_b = 8'h01; req1_cin = 1'b1; req1_valid = 1'b1;
      serve(0, 1'b0, 1'b1);

      // contention from reset: both valid throughout
      req0_valid = 1'b1; req1_valid = 1'b1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom);
         req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom);
         serve(0, 1'b0, 1'b0);
      end

      // backpressure then early rsp_ready
      serve(5, 1'b0, 1'b0);
      serve(0, 1'b1, 1'b0);

      // random traffic
      for (int k = 0; k < 20; k++) begin
         v = int'($urandom_range(1, 3));
         req0_valid = v[0]; req1_valid = v[1];
         req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom);
         req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom);
         serve(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      end

      // reset in the middle of RUN
      req0_valid = 1'b1; req1_valid = 1'b0;
      @(negedge clk);
      req0_valid = 1'b0;
      check("midrun_busy", busy, 1'b1);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1 check_all_zero("midrun_reset");
      @(negedge clk);
      rst = 1'b0;
      tb_last = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 8'h5A; req0_b = 8'hC3; req0_cin = 1'b1;
      req1_a = 8'h11; req1_b = 8'h22; req1_cin = 1'b0;
      serve(0, 1'b0, 1'b1);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // WIDTH=1 exhaustive
      for (int c = 0; c < 8; c++) begin
         w1_req0_a = 1'(c >> 2); w1_req0_b = 1'(c >> 1); w1_req0_cin = 1'(c);
         w1_req0_valid = 1'b1;
         #1 check("w1_ready", {w1_req0_ready, w1_busy}, 2'b10);
         @(negedge clk);
         w1_req0_valid = 1'b0;
         check("w1_fa", {w1_fa_a, w1_fa_b, w1_fa_cin, w1_busy}, {3'(c), 1'b1});
         @(negedge clk);
         check("w1_valid", {w1_rsp_valid, w1_rsp_id}, 2'b10);
         check("w1_result", {w1_rsp_cout, w1_rsp_sum}, tbl[c]);
         w1_rsp_ready = 1'b1;
         @(negedge clk);
         w1_rsp_ready = 1'b0;
         check("w1_idle", {w1_rsp_valid, w1_busy}, 2'b00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
